// File: rtl/dijkstra_path_writer_pkg.sv
// Shared definitions for the Dijkstra path writer: default widths, the
// "no predecessor" marker, the walker state type and the slot address helper.
// Optional build macro used by the walker: REVERSE_PATH_EN.

`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 16
`endif
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
// All-ones fill, so the marker takes the width of whatever it is compared with
`ifndef NO_PREVIOUS_NODE
`define NO_PREVIOUS_NODE '1
`endif

package dijkstra_path_writer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    CHECK,
    WRITE,
    GAP,
    LEN,
    DONE
  } path_writer_state_t;

  // Byte address of a result slot; callers truncate to their address width,
  // which makes the arithmetic wrap modulo 2^MADDR_WIDTH.
  function automatic logic [31:0] slot_address(input logic [31:0] base,
                                               input logic [31:0] slot,
                                               input int unsigned stride);
    return base + slot * stride;
  endfunction

endpackage

// File: rtl/dijkstra_path_writer_mem_write_master.sv
// Single-word write master for the shared memory bus. Latches a request,
// drives enable/addr/data until the memory acknowledges, then releases the
// bus for at least one cycle (the gap) while pulsing done.

module dijkstra_path_writer_mem_write_master #(
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req,
  input  logic [MADDR_WIDTH-1:0] addr,
  input  logic [MDATA_WIDTH-1:0] data,
  output logic                   done,
  output logic                   mem_write_enable,
  input  logic                   mem_write_ready,
  output logic [MADDR_WIDTH-1:0] mem_addr,
  output logic [MDATA_WIDTH-1:0] mem_write_data
);

  logic                   busy;
  logic [MADDR_WIDTH-1:0] addr_q;
  logic [MDATA_WIDTH-1:0] data_q;

  // Accept a request outside the gap cycle, hold it until ready, then release
  always_ff @(posedge clock) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (mem_write_ready) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (req && !done) begin
        busy   <= 1'b1;
        addr_q <= addr;
        data_q <= data;
      end
    end
  end

  assign mem_write_enable = busy ? 1'b1 : 1'bz;
  assign mem_addr         = busy ? addr_q : {MADDR_WIDTH{1'bz}};
  assign mem_write_data   = busy ? data_q : {MDATA_WIDTH{1'bz}};

endmodule

// File: rtl/dijkstra_path_writer.sv
// Walks prev[] from destination back to source and writes the path, one node
// per word, after a length word at result_address.
// Build macro REVERSE_PATH_EN: adds a COUNT pass so the path is written
// source-first; on error only the length word is written.

module dijkstra_path_writer
  import dijkstra_path_writer_pkg::*;
#(
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH,
  parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic [INDEX_WIDTH-1:0]                source,
  input  logic [INDEX_WIDTH-1:0]                destination,
  input  logic [INDEX_WIDTH-1:0]                number_of_nodes,
  input  logic [MADDR_WIDTH-1:0]                result_address,
  input  logic [MAX_NODES-1:0][INDEX_WIDTH-1:0] prev_vector,
  output logic                                  mem_write_enable,
  input  logic                                  mem_write_ready,
  output logic [MADDR_WIDTH-1:0]                mem_addr,
  output logic [MDATA_WIDTH-1:0]                mem_write_data,
  output logic                                  error,
  output logic                                  ready
);

  localparam int unsigned STRIDE = MADDR_WIDTH / 8;
  localparam int CW = INDEX_WIDTH + 1;
  localparam logic [CW-1:0] K_ONE = {{INDEX_WIDTH{1'b0}}, 1'b1};

  path_writer_state_t state;

  logic [INDEX_WIDTH-1:0] src_q;
  logic [INDEX_WIDTH-1:0] n_q;
  logic [INDEX_WIDTH-1:0] cur;
  logic [CW-1:0]          k;
  logic [MADDR_WIDTH-1:0] base_q;
  logic [MADDR_WIDTH-1:0] wr_addr;
  logic [MDATA_WIDTH-1:0] wr_data;
  logic                   req;
  logic                   issued;
  logic                   done;
  logic [INDEX_WIDTH-1:0] prev_cur;
  logic                   walk_bad;
  logic [CW-1:0]          slot;
`ifdef REVERSE_PATH_EN
  logic [INDEX_WIDTH-1:0] dst_q;
  logic [CW-1:0]          count_n;
`endif

  // prev[cur]; indices beyond the vector read as "no predecessor"
  always_comb begin
    prev_cur = `NO_PREVIOUS_NODE;
    for (int i = 0; i < MAX_NODES; i++) begin
      if (cur == INDEX_WIDTH'(i)) prev_cur = prev_vector[i];
    end
  end

  // Invalid node or more steps than nodes (loop)
  assign walk_bad = (cur >= n_q) || (k > {1'b0, n_q});

  // Result slot for the node currently being written
`ifdef REVERSE_PATH_EN
  assign slot = CW'(count_n - k + K_ONE);
`else
  assign slot = k;
`endif

  // Walker FSM: registered outputs, one request per node plus the length word
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      ready   <= 1'b0;
      error   <= 1'b0;
      req     <= 1'b0;
      issued  <= 1'b0;
      src_q   <= '0;
      n_q     <= '0;
      cur     <= '0;
      k       <= '0;
      base_q  <= '0;
      wr_addr <= '0;
      wr_data <= '0;
`ifdef REVERSE_PATH_EN
      dst_q   <= '0;
      count_n <= '0;
`endif
    end else begin
      req <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            src_q  <= source;
            n_q    <= number_of_nodes;
            base_q <= result_address;
            cur    <= destination;
            k      <= K_ONE;
            ready  <= 1'b0;
            error  <= 1'b0;
`ifdef REVERSE_PATH_EN
            dst_q  <= destination;
            state  <= COUNT;
`else
            state  <= CHECK;
`endif
          end
        end
`ifdef REVERSE_PATH_EN
        COUNT: begin
          if (walk_bad) begin
            error  <= 1'b1;
            issued <= 1'b0;
            state  <= LEN;
          end else if (cur == src_q) begin
            count_n <= k;
            cur     <= dst_q;
            k       <= K_ONE;
            state   <= CHECK;
          end else if (prev_cur == `NO_PREVIOUS_NODE) begin
            error  <= 1'b1;
            issued <= 1'b0;
            state  <= LEN;
          end else begin
            cur <= prev_cur;
            k   <= k + K_ONE;
          end
        end
`endif
        CHECK: begin
          issued <= 1'b0;
          if (walk_bad) begin
            error <= 1'b1;
            state <= LEN;
          end else begin
            state <= WRITE;
          end
        end
        WRITE: begin
          if (!issued) begin
            req     <= 1'b1;
            issued  <= 1'b1;
            wr_addr <= MADDR_WIDTH'(slot_address(32'(base_q), 32'(slot), STRIDE));
            wr_data <= MDATA_WIDTH'(cur);
          end else if (done) begin
            state <= GAP;
          end
        end
        GAP: begin
          issued <= 1'b0;
          if (cur == src_q) begin
            state <= LEN;
          end else if (prev_cur == `NO_PREVIOUS_NODE) begin
            error <= 1'b1;
            state <= LEN;
          end else begin
            cur   <= prev_cur;
            k     <= k + K_ONE;
            state <= CHECK;
          end
        end
        LEN: begin
          if (!issued) begin
            req     <= 1'b1;
            issued  <= 1'b1;
            wr_addr <= base_q;
            wr_data <= error ? '0 : MDATA_WIDTH'(k);
          end else if (done) begin
            ready <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (!enable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dijkstra_path_writer_mem_write_master #(
    .MADDR_WIDTH(MADDR_WIDTH),
    .MDATA_WIDTH(MDATA_WIDTH)
  ) u_master (
    .clock           (clock),
    .reset           (reset),
    .req             (req),
    .addr            (wr_addr),
    .data            (wr_data),
    .done            (done),
    .mem_write_enable(mem_write_enable),
    .mem_write_ready (mem_write_ready),
    .mem_addr        (mem_addr),
    .mem_write_data  (mem_write_data)
  );

endmodule

// File: tb/tb_dijkstra_path_writer.sv
// Self-checking bench for dijkstra_path_writer: BlockRam responder with
// programmable ready stall, reference path model, directed and random runs.
// Honours REVERSE_PATH_EN in the reference model.

module tb_dijkstra_path_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  source = '0;
  logic [3:0]  destination = '0;
  logic [3:0]  number_of_nodes = '0;
  logic [15:0] result_address = '0;
  logic [7:0][3:0] prev_vector = '0;
  wire         mem_write_enable;
  logic        mem_write_ready = 1'b0;
  wire  [15:0] mem_addr;
  wire  [15:0] mem_write_data;
  wire         error;
  wire         ready;

  int tests = 0;
  int fails = 0;

  logic [3:0] prev_m [8];
  int stall_cycles = 0;
  bit noise_en = 1'b0;

  // Monitor state (written only by the responder)
  int          log_a [$];
  int          log_d [$];
  int          stable_err = 0;
  int          gap_err = 0;
  bit          in_write = 1'b0;
  bit          acc_prev = 1'b0;
  int          wait_cnt = 0;
  logic [15:0] hold_a = '0;
  logic [15:0] hold_d = '0;

  // Expected write sequence
  int exp_a [$];
  int exp_d [$];
  bit exp_err;

  dijkstra_path_writer #(
    .MADDR_WIDTH(16), .MDATA_WIDTH(16), .MAX_NODES(8), .INDEX_WIDTH(4)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .source(source),
    .destination(destination), .number_of_nodes(number_of_nodes),
    .result_address(result_address), .prev_vector(prev_vector),
    .mem_write_enable(mem_write_enable), .mem_write_ready(mem_write_ready),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .error(error), .ready(ready)
  );

  always #5 clock = ~clock;

  // BlockRam responder: samples the bus at negedge, logs each accepted write
  always @(negedge clock) begin
    if (mem_write_enable === 1'b1) begin
      if (!in_write) begin
        if (acc_prev) gap_err <= gap_err + 1;
        hold_a <= mem_addr;
        hold_d <= mem_write_data;
      end else if (mem_addr !== hold_a || mem_write_data !== hold_d) begin
        stable_err <= stable_err + 1;
      end
      if (wait_cnt >= stall_cycles) begin
        mem_write_ready <= 1'b1;
        log_a.push_back(int'(mem_addr));
        log_d.push_back(int'(mem_write_data));
        in_write <= 1'b0;
        acc_prev <= 1'b1;
        wait_cnt <= 0;
      end else begin
        mem_write_ready <= 1'b0;
        in_write <= 1'b1;
        acc_prev <= 1'b0;
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      mem_write_ready <= noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      in_write <= 1'b0;
      acc_prev <= 1'b0;
      wait_cnt <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: list the nodes from destination to source, then place them
  task automatic build_expected(input int src, input int dst, input int n, input int base);
    int path[$];
    int cur;
    int len;
    bit err;
    err = 1'b0;
    cur = dst;
    exp_a.delete();
    exp_d.delete();
    forever begin
      if (cur >= n || path.size() >= n) begin err = 1'b1; break; end
      path.push_back(cur);
      if (cur == src) break;
      if (prev_m[cur] == `NO_PREVIOUS_NODE) begin err = 1'b1; break; end
      cur = int'(prev_m[cur]);
    end
    len = path.size();
`ifdef REVERSE_PATH_EN
    if (!err) begin
      for (int i = 0; i < len; i++) begin
        exp_a.push_back((base + (len - i) * 2) & 16'hFFFF);
        exp_d.push_back(path[i]);
      end
    end
`else
    for (int i = 0; i < len; i++) begin
      exp_a.push_back((base + (i + 1) * 2) & 16'hFFFF);
      exp_d.push_back(path[i]);
    end
`endif
    exp_a.push_back(base & 16'hFFFF);
    exp_d.push_back(err ? 0 : len);
    exp_err = err;
  endtask

  task automatic start(input int src, input int dst, input int n, input int base);
    @(negedge clock);
    for (int i = 0; i < 8; i++) prev_vector[i] = prev_m[i];
    source = 4'(src);
    destination = 4'(dst);
    number_of_nodes = 4'(n);
    result_address = 16'(base);
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
  endtask

  task automatic run(input string tag, input int src, input int dst, input int n,
                     input int base, input int stall, input bit noise);
    int s0, st0, g0, got;
    bit seen;
    build_expected(src, dst, n, base);
    stall_cycles = stall;
    noise_en = noise;
    s0 = log_a.size();
    st0 = stable_err;
    g0 = gap_err;
    start(src, dst, n, base);
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clock);
      if (ready === 1'b1) seen = 1'b1;
    end
    chk({tag, "_ready"}, ready, 1'b1);
    chk({tag, "_error"}, error, exp_err);
    got = log_a.size() - s0;
    chk({tag, "_nwrites"}, got, exp_a.size());
    for (int i = 0; i < exp_a.size() && i < got; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), log_a[s0 + i], exp_a[i]);
      chk($sformatf("%s_data%0d", tag, i), log_d[s0 + i], exp_d[i]);
    end
    chk({tag, "_stable"}, stable_err - st0, 0);
    chk({tag, "_gap"}, gap_err - g0, 0);
    chk({tag, "_bus_idle"}, {31'b0, mem_write_enable === 1'b1}, 0);
  endtask

  task automatic set_chain();
    prev_m[0] = `NO_PREVIOUS_NODE;
    for (int i = 1; i < 8; i++) prev_m[i] = 4'(i - 1);
  endtask

  initial begin
    int s0;
    bit hit;
    set_chain();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_ready", ready, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_bus", {31'b0, mem_write_enable === 1'b1}, 0);

    // 1: full chain
    run("t1_chain", 0, 7, 8, 'h40, 0, 1'b0);
    // 2: source == destination
    run("t2_single", 3, 3, 8, 'h40, 0, 1'b1);
    // 3: unreachable
    prev_m[7] = `NO_PREVIOUS_NODE;
    run("t3_noprev", 0, 7, 8, 'h40, 1, 1'b0);
    // 4: loop between 5 and 6
    set_chain();
    prev_m[5] = 4'd6;
    prev_m[6] = 4'd5;
    run("t4_loop", 0, 5, 8, 'h40, 0, 1'b0);
    // 5: stalled memory
    set_chain();
    run("t5_stall", 0, 7, 8, 'h40, 5, 1'b1);
    // boundary: destination out of range, address wrap
    run("t_dst_oob", 0, 8, 8, 'h40, 0, 1'b0);
    run("t_wrap", 0, 7, 8, 'hFFF8, 0, 1'b0);

    // 6: reset during the third slot write
    stall_cycles = 3;
    noise_en = 1'b0;
    s0 = log_a.size();
    start(0, 7, 8, 'h40);
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(negedge clock);
      if (log_a.size() - s0 == 2 && mem_write_enable === 1'b1) hit = 1'b1;
    end
    chk("t6_reached_slot3", hit, 1'b1);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    chk("t6_bus_z", {31'b0, mem_write_enable === 1'b1}, 0);
    chk("t6_ready", ready, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    chk("t6_partial", log_a.size() - s0, 2);
    run("t6_rerun", 0, 7, 8, 'h40, 0, 1'b0);

    // Random graphs
    for (int r = 0; r < 25; r++) begin
      int src, dst, n;
      bit chain;
      chain = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin
        if (chain) prev_m[i] = (i == 0) ? `NO_PREVIOUS_NODE : 4'(i - 1);
        else prev_m[i] = ($urandom_range(0, 3) == 0) ? `NO_PREVIOUS_NODE
                                                     : 4'($urandom_range(0, 7));
      end
      n = $urandom_range(1, 8);
      src = chain ? 0 : $urandom_range(0, 7);
      dst = $urandom_range(0, 8);
      run($sformatf("rnd%0d", r), src, dst, n, $urandom_range(0, 65535),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
